// File: rtl/ram_gen_pkg.sv
// Shared types and constants for the generic synchronous RAM.
// FSM state encoding and READ_MODE selector values.
package ram_gen_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        INIT  = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int RM_READ_FIRST  = 0;
    localparam int RM_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_gen_array.sv
// Single-port storage: synchronous write, combinational read.
// Ports: clk, we, adr, din (write word), dout (mem[adr]).
module ram_gen_array #(
    parameter int W      = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] adr,
    input  logic [W-1:0]      din,
    output logic [W-1:0]      dout
);

    logic [W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[adr] <= din;
    end

    assign dout = mem[adr];

endmodule

// File: rtl/ram_gen_sync.sv
// Synchronous RAM with reset-time zero fill and registered read port.
// Ports: CLK, RST_N (async low), CE, WE, ADR, DIN -> DOUT, DVALID, READY;
// PERR (parity error) exists only when RAM_GEN_PARITY_EN is defined.
module ram_gen_sync
    import ram_gen_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_W     = 6,
    parameter int READ_MODE  = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADR,
    input  logic [WIDTH-1:0]  DIN,
    output logic [WIDTH-1:0]  DOUT,
    output logic              DVALID,
    output logic              READY
`ifdef RAM_GEN_PARITY_EN
    ,
    output logic              PERR
`endif
);

`ifdef RAM_GEN_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] cnt;
    logic              acc;
    logic              a_we;
    logic [ADDR_W-1:0] a_adr;
    logic [MW-1:0]     a_din;
    logic [MW-1:0]     a_dout;
    logic [MW-1:0]     wword;
    logic [WIDTH-1:0]  rdata;

    assign READY = (state == RUN);
    assign acc   = READY & CE;

`ifdef RAM_GEN_PARITY_EN
    // Stored word is {parity, data}; parity bit makes the total even.
    assign wword = {^DIN, DIN};
`else
    assign wword = DIN;
`endif
    assign rdata = a_dout[WIDTH-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= RESET;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RESET:   state_nx = (INIT_CLEAR != 0) ? INIT : RUN;
            INIT:    if (&cnt) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = RESET;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)              cnt <= '0;
        else if (state == INIT)  cnt <= cnt + ADDR_W'(1);
        else                     cnt <= '0;
    end

    // INIT owns the array port; zero data also carries zero parity.
    always_comb begin
        a_we  = 1'b0;
        a_adr = ADR;
        a_din = '0;
        if (state == INIT) begin
            a_we  = 1'b1;
            a_adr = cnt;
        end else if (acc && WE) begin
            a_we  = 1'b1;
            a_din = wword;
        end
    end

    ram_gen_array #(
        .W      (MW),
        .ADDR_W (ADDR_W)
    ) u_arr (
        .clk  (CLK),
        .we   (a_we),
        .adr  (a_adr),
        .din  (a_din),
        .dout (a_dout)
    );

    // Combinational read sees the pre-write word on a write edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DOUT   <= '0;
            DVALID <= 1'b0;
        end else begin
            DVALID <= acc;
            if (acc) begin
                if (WE && READ_MODE == RM_WRITE_FIRST) DOUT <= DIN;
                else                                   DOUT <= rdata;
            end
        end
    end

`ifdef RAM_GEN_PARITY_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) PERR <= 1'b0;
        else        PERR <= acc & ~WE & (^a_dout);
    end
`endif

endmodule

// File: tb/tb_ram_gen_sync.sv
// Self-checking bench for ram_gen_sync: vector table, reset/INIT
// sequences, and random traffic against a behavioural memory model.
module tb_ram_gen_sync;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       CE = 1'b0;
    logic       WE = 1'b0;
    logic [5:0] ADR = '0;
    logic [7:0] DIN = '0;

    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2;
    logic       r0, r1, r2;
`ifdef RAM_GEN_PARITY_EN
    logic       p0, p1, p2;
`endif

    always #5 CLK = ~CLK;

    ram_gen_sync #(.READ_MODE(ram_gen_pkg::RM_READ_FIRST)) u0 (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .WE(WE), .ADR(ADR), .DIN(DIN),
        .DOUT(d0), .DVALID(v0), .READY(r0)
`ifdef RAM_GEN_PARITY_EN
        , .PERR(p0)
`endif
    );

    ram_gen_sync #(.READ_MODE(ram_gen_pkg::RM_WRITE_FIRST)) u1 (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .WE(WE), .ADR(ADR), .DIN(DIN),
        .DOUT(d1), .DVALID(v1), .READY(r1)
`ifdef RAM_GEN_PARITY_EN
        , .PERR(p1)
`endif
    );

    ram_gen_sync #(.INIT_CLEAR(0)) u2 (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .WE(WE), .ADR(ADR), .DIN(DIN),
        .DOUT(d2), .DVALID(v2), .READY(r2)
`ifdef RAM_GEN_PARITY_EN
        , .PERR(p2)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Model: edges since reset release, memory image, expected outputs.
    int         edges;
    logic       m_ready;
    logic [7:0] m [64];
    logic       bad [64];
    logic [7:0] e0, e1;
    logic       ev, ep;

    typedef struct {
        logic       ce;
        logic       we;
        logic [5:0] a;
        logic [7:0] d;
        logic [7:0] x0;
        logic [7:0] x1;
        logic       xv;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic ce, input logic we,
                        input logic [5:0] a, input logic [7:0] d);
        logic [7:0] old;
        CE = ce; WE = we; ADR = a; DIN = d;
        @(posedge CLK);
        edges++;
        ev = m_ready && ce;
        ep = 1'b0;
        if (ev) begin
            old = m[a];
            e0 = old;
            e1 = we ? d : old;
            if (we) begin
                m[a] = d;
                bad[a] = 1'b0;
            end else begin
                ep = bad[a];
            end
        end
        if (edges == 65) begin
            for (int i = 0; i < 64; i++) begin
                m[i] = 8'h00;
                bad[i] = 1'b0;
            end
        end
        m_ready = (edges >= 65);
        #1;
        chk("ready0", 8'(r0), 8'(m_ready));
        chk("ready1", 8'(r1), 8'(m_ready));
        chk("ready2", 8'(r2), 8'(edges >= 1));
        chk("dvalid0", 8'(v0), 8'(ev));
        chk("dvalid1", 8'(v1), 8'(ev));
        chk("dout0", d0, e0);
        chk("dout1", d1, e1);
`ifdef RAM_GEN_PARITY_EN
        chk("perr0", 8'(p0), 8'(ep));
        chk("perr1", 8'(p1), 8'(ep));
`endif
    endtask

    // Assert reset between edges, check outputs drop at once, release.
    task automatic do_reset();
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_dout0", d0, 8'h00);
        chk("rst_dout1", d1, 8'h00);
        chk("rst_dout2", d2, 8'h00);
        chk("rst_dvalid", 8'({v0, v1, v2}), 8'h00);
        chk("rst_ready", 8'({r0, r1, r2}), 8'h00);
`ifdef RAM_GEN_PARITY_EN
        chk("rst_perr", 8'({p0, p1, p2}), 8'h00);
`endif
        e0 = 8'h00; e1 = 8'h00; ev = 1'b0; ep = 1'b0;
        m_ready = 1'b0;
        @(posedge CLK);
        #3;
        RST_N = 1'b1;
        edges = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) bad[i] = 1'b0;
        edges = 0;

        tbl[0]  = '{1, 1,  5, 8'hA5, 8'h00, 8'hA5, 1};
        tbl[1]  = '{1, 0,  5, 8'h00, 8'hA5, 8'hA5, 1};
        tbl[2]  = '{1, 1,  9, 8'h11, 8'h00, 8'h11, 1};
        tbl[3]  = '{1, 1,  9, 8'h22, 8'h11, 8'h22, 1};
        tbl[4]  = '{1, 0,  9, 8'h00, 8'h22, 8'h22, 1};
        tbl[5]  = '{0, 0,  9, 8'h00, 8'h22, 8'h22, 0};
        tbl[6]  = '{1, 0, 63, 8'h00, 8'h00, 8'h00, 1};
        tbl[7]  = '{1, 0,  0, 8'h00, 8'h00, 8'h00, 1};
        tbl[8]  = '{1, 0, 31, 8'h00, 8'h00, 8'h00, 1};
        tbl[9]  = '{1, 1, 63, 8'hFF, 8'h00, 8'hFF, 1};
        tbl[10] = '{1, 0, 63, 8'h00, 8'hFF, 8'hFF, 1};
        tbl[11] = '{0, 1,  0, 8'h77, 8'hFF, 8'hFF, 0};
        tbl[12] = '{1, 0,  0, 8'h00, 8'h00, 8'h00, 1};

        #1;
        do_reset();
        repeat (64) step(0, 0, 0, 8'h00);
        chk("ready_low_64", 8'(r0), 8'h00);
        step(0, 0, 0, 8'h00);
        chk("ready_high", 8'(r0), 8'h01);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].ce, tbl[i].we, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_dout0", i), d0, tbl[i].x0);
            chk($sformatf("tbl%0d_dout1", i), d1, tbl[i].x1);
            chk($sformatf("tbl%0d_dv", i), 8'(v0), 8'(tbl[i].xv));
        end

        // Access during INIT is ignored; reset at INIT cycle 20 restarts.
        do_reset();
        repeat (5) step(0, 0, 0, 8'h00);
        step(1, 1, 3, 8'hFF);
        while (edges < 21) step(0, 0, 0, 8'h00);
        do_reset();
        repeat (65) step(0, 0, 0, 8'h00);
        step(1, 0, 3, 8'h00);
        chk("init_write_ignored", d0, 8'h00);

        // Reset in RUN with nonzero DOUT; INIT then clears the array.
        step(1, 1, 10, 8'h5A);
        step(1, 0, 10, 8'h00);
        do_reset();
        repeat (65) step(0, 0, 0, 8'h00);
        step(1, 0, 10, 8'h00);
        chk("cleared_after_reinit", d1, 8'h00);

        repeat (400) begin
            step(($urandom_range(3) != 0), 1'($urandom),
                 6'($urandom), 8'($urandom));
        end

`ifdef RAM_GEN_PARITY_EN
        step(1, 1, 7, 8'h0F);
        #2;
        u0.u_arr.mem[7][0] = 1'b0;
        u1.u_arr.mem[7][0] = 1'b0;
        m[7] = 8'h0E;
        bad[7] = 1'b1;
        step(1, 0, 7, 8'h00);
        chk("perr_set", 8'(p0), 8'h01);
        step(1, 0, 8, 8'h00);
        chk("perr_clean", 8'(p0), 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_gen_sync.md
RAM_GEN_SYNC -- requirements
Module: ram_gen_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 SHALL have parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter READ_MODE, default 0: 0 = read-first, 1 = write-first.
REQ-004 SHALL have parameter INIT_CLEAR, default 1: 1 = zero-fill memory after reset.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port CE, input, 1 bit: access enable.
REQ-008 SHALL have port WE, input, 1 bit: write enable, qualified by CE.
REQ-009 SHALL have port ADR, input, ADDR_W bits: word address.
REQ-010 SHALL have port DIN, input, WIDTH bits: write data.
REQ-011 SHALL have port DOUT, output, WIDTH bits: registered read data.
REQ-012 SHALL have port DVALID, output, 1 bit: DOUT updated this cycle.
REQ-013 SHALL have port READY, output, 1 bit: block accepts accesses.

Function
REQ-014 SHALL implement an FSM with states RESET, INIT and RUN.
REQ-015 SHALL leave RESET on the first CLK edge with RST_N high: go to INIT if INIT_CLEAR=1, else to RUN.
REQ-016 In INIT, SHALL write zero to address 0..DEPTH-1, one word per cycle, using an internal counter.
REQ-017 In INIT, after address DEPTH-1 is written, SHALL go to RUN; the full zero-fill takes DEPTH cycles.
REQ-018 SHALL hold READY low in RESET and INIT and high in RUN.
REQ-019 SHALL ignore CE/WE/ADR/DIN while READY is low, with no memory write and DVALID low.
REQ-020 For a write (RUN, CE=1, WE=1), SHALL store DIN at ADR on that edge.
REQ-021 For a read (RUN, CE=1, WE=0), SHALL present mem[ADR] on DOUT after the edge and assert DVALID for exactly that cycle (latency 1).
REQ-022 On a write, SHALL also assert DVALID; DOUT = previous mem[ADR] if READ_MODE=0, DIN if READ_MODE=1.
REQ-023 With CE=0, SHALL hold DOUT and drive DVALID low.
REQ-024 Back-to-back accesses SHALL be accepted every cycle with no bubbles.
REQ-025 A read of an address written on the previous cycle SHALL return the new data.
REQ-026 With INIT_CLEAR=0, memory contents after reset are undefined; DOUT is still 0 after reset.

Reset
REQ-027 RST_N low SHALL immediately force DOUT=0, DVALID=0, READY=0, FSM=RESET and INIT counter=0, independent of CLK.
REQ-028 Reset asserted during INIT or RUN SHALL abort the current operation; release SHALL restart the sequence of REQ-015.
REQ-029 Reset SHALL not itself clear the memory array; only INIT clears it.

Configuration
REQ-030 Macro RAM_GEN_PARITY_EN, when defined, SHALL add one even-parity bit per word, computed and stored on every write (including INIT writes).
REQ-031 With RAM_GEN_PARITY_EN defined, SHALL add output PERR (1 bit), asserted with DVALID on a read whose stored parity mismatches the data; otherwise PERR=0; reset value 0.
REQ-032 Without RAM_GEN_PARITY_EN, SHALL have no PERR port and no parity storage, with behaviour otherwise identical.

Structure
REQ-033 The shared package/include ram_gen_pkg SHALL hold the FSM state encodings (RESET=2'd0, INIT=2'd1, RUN=2'd2) and the READ_MODE constants (RM_READ_FIRST=0, RM_WRITE_FIRST=1).
REQ-034 Storage SHALL be a sub-module ram_gen_array: single-port array with synchronous write and combinational read, width WIDTH (+1 with parity).
REQ-035 The FSM, INIT counter, output registers and parity logic SHALL reside in ram_gen_sync.

Verification
REQ-036 Reset release with defaults: READY low for 64 cycles, then high; reads of addresses 0, 31 and 63 return 8'h00 with DVALID.
REQ-037 Write 8'hA5 to address 5, then read address 5 on the next cycle: DOUT=8'hA5 and DVALID=1 one cycle after the read.
REQ-038 Write-collision test, mem[9]=8'h11, then write 8'h22 to address 9:
- READ_MODE=0: DOUT=8'h11.
- READ_MODE=1: DOUT=8'h22.
REQ-039 Assert RST_N low at INIT cycle 20: DOUT, DVALID and READY go to 0 immediately; on release, INIT restarts and READY rises after 64 cycles.
REQ-040 CE=1 during INIT with write of 8'hFF to address 3: ignored; after READY, a read of address 3 returns 8'h00.
REQ-041 With RAM_GEN_PARITY_EN, write 8'h0F to address 7, flip data bit 0 by hierarchical deposit, then read address 7: PERR=1 with DVALID; a clean read gives PERR=0.
